ntt_stage_sched: RTL and testbench

- Parametrised control scheduler for the multi-bank NTT datapath. Successor to the fixed 2-BFU, 256-point, 7-cycle-latency controller.
- Sequences all stages of a forward NTT, an inverse NTT or a single pointwise-multiply pass for 2^LOG_N coefficients across 2^LOG_NBF butterfly units.
- Drives the address generator (stage/count), the bank read/write/enable strobes and the BFU mode select.
- Adds a start/busy/done handshake, abort, and automatic pipeline drain between stages to remove read-after-write hazards.

---
 rtl/ntt_stage_sched.sv | 136 +++++++++++++
 tb/tb_ntt_stage_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// Control scheduler for the multi-bank NTT datapath: sequences read passes per stage,
// drains the BFU pipeline between stages and delays read strobes into write strobes.
module ntt_stage_sched #(
  parameter int unsigned LOG_N    = 8,
  parameter int unsigned LOG_NBF  = 1,
  parameter int unsigned PIPE_LAT = 7,
  parameter int unsigned STG_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [STG_W-1:0]           p,
  output logic [LOG_N-2-LOG_NBF:0]   cnt,
  output logic                       ren,
  output logic                       wen,
  output logic                       en,
  output logic [1:0]                 sel
);

  localparam int unsigned CW = LOG_N - 1 - LOG_NBF;
  localparam int unsigned DW = $clog2(PIPE_LAT + 1);
  localparam logic [DW-1:0] DLAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [STG_W-1:0]      p_q, p_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic [1:0]            sel_q, sel_d;
  logic                  done_q, done_d;
  logic [PIPE_LAT-1:0]   dly_q, dly_d;
  logic [STG_W-1:0]      p_last;
  logic                  rd;

  assign rd     = (state_q == READ);
  // PWM is a single pass; NTT/INTT run LOG_N stages
  assign p_last = (sel_q == 2'd2) ? '0 : STG_W'(LOG_N - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    dly_d   = '0;

    dly_d[0] = rd;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (start && (mode != 2'd3)) begin
          state_d = READ;
          p_d     = '0;
          cnt_d   = '0;
          sel_d   = mode;
        end
      end
      READ: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = DRAIN;
          cnt_d   = '0;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (dcnt_q == DLAST) begin
          dcnt_d = '0;
          if (p_q == p_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = READ;
            p_d     = p_q + 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides the stepping above, including any completion in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      p_d     = '0;
      cnt_d   = '0;
      dcnt_d  = '0;
      done_d  = 1'b0;
      dly_d   = '0;
    end
  end

  assign ren  = rd;
  assign wen  = dly_q[PIPE_LAT-1];
  assign en   = rd | dly_q[PIPE_LAT-1];
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign p    = p_q;
  assign cnt  = cnt_q;
  assign sel  = sel_q;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: default build (N=256, 2 BFU, lat 7) and a small
// build (N=16, 2 BFU, lat 3), compared per cycle against the stage timing formula.
module tb_ntt_stage_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  bit         which = 1'b0;
  logic       start_r = 1'b0;
  logic [1:0] mode_r = 2'd0;
  logic       abort_r = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic       a_start, a_abort, b_start, b_abort;
  logic       a_busy, a_done, a_ren, a_wen, a_en;
  logic       b_busy, b_done, b_ren, b_wen, b_en;
  logic [3:0] a_p, b_p;
  logic [5:0] a_cnt;
  logic [1:0] b_cnt;
  logic [1:0] a_sel, b_sel;

  assign a_start = start_r & ~which;
  assign a_abort = abort_r & ~which;
  assign b_start = start_r & which;
  assign b_abort = abort_r & which;

  ntt_stage_sched #(.LOG_N(8), .LOG_NBF(1), .PIPE_LAT(7), .STG_W(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(mode_r), .abort(a_abort),
    .busy(a_busy), .done(a_done), .p(a_p), .cnt(a_cnt),
    .ren(a_ren), .wen(a_wen), .en(a_en), .sel(a_sel)
  );

  ntt_stage_sched #(.LOG_N(4), .LOG_NBF(1), .PIPE_LAT(3), .STG_W(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(mode_r), .abort(b_abort),
    .busy(b_busy), .done(b_done), .p(b_p), .cnt(b_cnt),
    .ren(b_ren), .wen(b_wen), .en(b_en), .sel(b_sel)
  );

  localparam logic [31:0] P_MASK = 32'h0000_0F00;

  // layout: busy,done,ren,wen,en,sel[1:0],p[3:0],cnt[7:0]
  function automatic logic [31:0] pk(input logic b, d, r, w, e, input logic [1:0] s,
                                     input logic [3:0] pp, input logic [7:0] c);
    return {13'd0, b, d, r, w, e, s, pp, c};
  endfunction

  logic [31:0] obs;
  always_comb begin
    obs = '0;
    if (which) obs = pk(b_busy, b_done, b_ren, b_wen, b_en, b_sel, b_p, 8'(b_cnt));
    else       obs = pk(a_busy, a_done, a_ren, a_wen, a_en, a_sel, a_p, 8'(a_cnt));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in cycle t (start edge = cycle 0) for C reads, latency L, S stages.
  function automatic logic [31:0] model(input int c, input int l, input int s, input int m,
                                        input int t);
    int off, st;
    logic r, w;
    if (t > s * (c + l)) return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(m), 4'd0, 8'd0);
    off = (t - 1) % (c + l);
    st  = (t - 1) / (c + l);
    r   = (off < c);
    w   = (off >= l) && (off < l + c);
    return pk(1'b1, 1'b0, r, w, r | w, 2'(m), 4'(st), r ? 8'(off) : 8'd0);
  endfunction

  // hold=1 keeps start high and switches mode to PWM while busy (both must be ignored).
  task automatic run_op(input int c, input int l, input int s, input int m, input bit hold);
    int last;
    logic [31:0] exp, got;
    last = s * (c + l) + 1;
    mode_r  = 2'(m);
    start_r = 1'b1;
    step();
    if (hold) mode_r = 2'd2;
    else      start_r = 1'b0;
    for (int t = 1; t <= last; t++) begin
      exp = model(c, l, s, m, t);
      got = obs;
      if (t == last) begin
        exp = exp & ~P_MASK;
        got = got & ~P_MASK;
      end
      check($sformatf("dut%0d mode%0d cyc%0d", which, m, t), got, exp);
      if (t < last) step();
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs, 32'd0);
    which = 1'b1;
    #0 check("reset_b", obs, 32'd0);
    which = 1'b0;
    rst = 1'b0;
    step();
    check("idle_a", obs, 32'd0);

    // reserved mode: start ignored
    mode_r  = 2'd3;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    check("mode3_ignored", obs, 32'd0);

    // full NTT, then PWM started in the done cycle
    run_op(64, 7, 8, 0, 1'b0);
    run_op(64, 7, 1, 2, 1'b0);
    step();
    check("pwm_after_done", obs, pk(0, 0, 0, 0, 0, 2'd2, 4'd0, 8'd0));

    // asynchronous reset in the middle of DRAIN
    mode_r  = 2'd2;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (65) step();
    check("pre_rst_drain", obs, pk(1, 0, 0, 1, 1, 2'd2, 4'd0, 8'd0));
    #2 rst = 1'b1;
    #1 check("async_rst", obs, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_idle", obs, 32'd0);

    // abort in stage 1 at cycle 100, restart at cycle 105
    mode_r  = 2'd0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (99) step();
    check("pre_abort_c100", obs, pk(1, 0, 1, 1, 1, 2'd0, 4'd1, 8'd28));
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    check("abort_c101", obs, 32'd0);
    for (int t = 102; t <= 105; t++) begin
      step();
      check($sformatf("abort_idle_c%0d", t), obs, 32'd0);
    end
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    check("restart_c106", obs, pk(1, 0, 1, 0, 1, 2'd0, 4'd0, 8'd0));
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    check("abort2_idle", obs, 32'd0);

    // small build: INTT, then back-to-back with start held, then PWM
    which = 1'b1;
    #0;
    run_op(4, 3, 4, 1, 1'b0);
    run_op(4, 3, 4, 1, 1'b1);
    run_op(4, 3, 1, 2, 1'b0);
    step();
    check("b_idle_end", obs, pk(0, 0, 0, 0, 0, 2'd2, 4'd0, 8'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
